// File: rtl/studio2_dma_engine.sv
// Display DMA engine for the Studio II pixie video path.
// A rising edge on dmao fetches one line burst of BYTES_PER_LINE bytes from
// display RAM at BASE+ptr and hands each byte to the pixie with a one-cycle
// pix_valid strobe. Each RAM row is shown on REPEAT consecutive display lines,
// so the row is re-read until the last repeat, which advances to the next row.
// A rising edge on int_in restarts the frame at the top of the display page.
// Ports:
//   clk, resetq        clock, asynchronous active-low reset
//   dmao, int_in       pixie DMA-out request and frame interrupt (edge-sensed)
//   mem_rd, mem_a      display RAM read strobe and address
//   mem_q              RAM read data, valid the cycle after mem_rd
//   pix_data/pix_valid byte and strobe to the pixie data input
//   sc, dma_busy       CPU state code and bus stall, decoded from burst state
//   ovr                sticky flag: dmao edge arrived while a burst was active
module studio2_dma_engine #(
   parameter logic [15:0] BASE           = 16'h0900,
   parameter int unsigned BYTES_PER_LINE = 8,
   parameter int unsigned REPEAT         = 4
) (
   input  logic        clk,
   input  logic        resetq,
   input  logic        dmao,
   input  logic        int_in,
   output logic        mem_rd,
   output logic [15:0] mem_a,
   input  logic [7:0]  mem_q,
   output logic [7:0]  pix_data,
   output logic        pix_valid,
   output logic [1:0]  sc,
   output logic        dma_busy,
   output logic        ovr
);

   localparam int unsigned BC_W = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
   localparam int unsigned LN_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
   localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES_PER_LINE - 1);
   localparam logic [LN_W-1:0] LAST_LINE = LN_W'(REPEAT - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WAIT = 2'd2} state_t;

   state_t          state, state_nxt;
   logic [7:0]      ptr, ptr_nxt;
   logic [7:0]      row_start, row_start_nxt;
   logic [BC_W-1:0] byte_cnt, byte_cnt_nxt;
   logic [LN_W-1:0] line_cnt, line_cnt_nxt;
   logic [7:0]      pix_data_nxt;
   logic            pix_valid_nxt;
   logic            ovr_nxt;
   logic            dmao_q, int_q;
   logic            dmao_rise, int_rise;

   assign dmao_rise = dmao & ~dmao_q;
   assign int_rise  = int_in & ~int_q;

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         state     <= IDLE;
         ptr       <= 8'h00;
         row_start <= 8'h00;
         byte_cnt  <= '0;
         line_cnt  <= '0;
         pix_data  <= 8'h00;
         pix_valid <= 1'b0;
         mem_rd    <= 1'b0;
         mem_a     <= 16'h0000;
         sc        <= 2'b01;
         dma_busy  <= 1'b0;
         ovr       <= 1'b0;
         dmao_q    <= 1'b0;
         int_q     <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         row_start <= row_start_nxt;
         byte_cnt  <= byte_cnt_nxt;
         line_cnt  <= line_cnt_nxt;
         pix_data  <= pix_data_nxt;
         pix_valid <= pix_valid_nxt;
         // Bus-side outputs are registered from the next state so they line up with it
         mem_rd    <= (state_nxt == READ);
         mem_a     <= (state_nxt == READ) ? (BASE + {8'h00, ptr_nxt}) : 16'h0000;
         sc        <= (state_nxt != IDLE) ? 2'b10 : 2'b01;
         dma_busy  <= (state_nxt != IDLE);
         ovr       <= ovr_nxt;
         dmao_q    <= dmao;
         int_q     <= int_in;
      end
   end

   // Next-state and datapath update; frame restart overrides everything
   always_comb begin
      state_nxt     = state;
      ptr_nxt       = ptr;
      row_start_nxt = row_start;
      byte_cnt_nxt  = byte_cnt;
      line_cnt_nxt  = line_cnt;
      pix_data_nxt  = pix_data;
      pix_valid_nxt = 1'b0;
      ovr_nxt       = ovr;

      if (int_rise) begin
         ptr_nxt       = 8'h00;
         row_start_nxt = 8'h00;
         byte_cnt_nxt  = '0;
         line_cnt_nxt  = '0;
         ovr_nxt       = 1'b0;
         // A dmao edge in the same cycle starts a burst at the top of the page
         state_nxt     = dmao_rise ? READ : IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (dmao_rise) state_nxt = READ;
            end
            READ: begin
               if (dmao_rise) ovr_nxt = 1'b1;
               state_nxt = WAIT;
            end
            WAIT: begin
               if (dmao_rise) ovr_nxt = 1'b1;
               pix_data_nxt  = mem_q;
               pix_valid_nxt = 1'b1;
               ptr_nxt       = ptr + 8'h01;
               if (byte_cnt < LAST_BYTE) begin
                  byte_cnt_nxt = byte_cnt + BC_W'(1);
                  state_nxt    = READ;
               end else begin
                  // End of line: counter restarts for the next burst
                  byte_cnt_nxt = '0;
                  state_nxt    = IDLE;
                  if (line_cnt == LAST_LINE) begin
                     line_cnt_nxt  = '0;
                     row_start_nxt = ptr + 8'h01;
                  end else begin
                     line_cnt_nxt = line_cnt + LN_W'(1);
                     ptr_nxt      = row_start;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_studio2_dma_engine.sv
// Bench for studio2_dma_engine: RAM model holding addr[7:0]+1 in the display
// page, expected read addresses and pixel bytes queued from a reference model
// of ptr/row/line, and per-scenario timing checks.
module tb_studio2_dma_engine;

   localparam logic [15:0] BASE = 16'h0900;

   logic        clk = 1'b0;
   logic        resetq;
   logic        dmao;
   logic        int_in;
   logic        mem_rd;
   logic [15:0] mem_a;
   logic [7:0]  mem_q;
   logic [7:0]  pix_data;
   logic        pix_valid;
   logic [1:0]  sc;
   logic        dma_busy;
   logic        ovr;

   int errors = 0;
   int checks = 0;

   logic [15:0] exp_addr[$];
   logic [7:0]  exp_data[$];
   logic [15:0] first_rd_addr;
   bit          seen_first;

   // Reference model of the display pointer state
   logic [7:0]  m_ptr, m_row;
   int          m_line;

   studio2_dma_engine #(.BASE(BASE), .BYTES_PER_LINE(8), .REPEAT(4)) dut (
      .clk(clk), .resetq(resetq), .dmao(dmao), .int_in(int_in),
      .mem_rd(mem_rd), .mem_a(mem_a), .mem_q(mem_q),
      .pix_data(pix_data), .pix_valid(pix_valid), .sc(sc),
      .dma_busy(dma_busy), .ovr(ovr)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ram_byte(input logic [15:0] a);
      if (a[15:8] == 8'h09) return a[7:0] + 8'h01;
      return 8'hEE;
   endfunction

   // Synchronous RAM: data valid the cycle after the address is presented
   always @(posedge clk) mem_q <= ram_byte(mem_a);

   task automatic model_restart();
      m_ptr = 8'h00; m_row = 8'h00; m_line = 0;
   endtask

   // Queue the expected reads/bytes of one full burst and advance the model
   task automatic push_burst();
      logic [15:0] a;
      for (int i = 0; i < 8; i++) begin
         a = BASE + {8'h00, m_ptr};
         exp_addr.push_back(a);
         exp_data.push_back(ram_byte(a));
         m_ptr = m_ptr + 8'h01;
      end
      if (m_line == 3) begin
         m_line = 0; m_row = m_ptr;
      end else begin
         m_line = m_line + 1; m_ptr = m_row;
      end
   endtask

   // Scoreboard consumer: called once per cycle at the falling edge
   task automatic tick_sb();
      logic [15:0] ea;
      logic [7:0]  ed;
      if (resetq && mem_rd) begin
         if (!seen_first) begin first_rd_addr = mem_a; seen_first = 1'b1; end
         checks++;
         if (exp_addr.size() == 0) begin
            errors++; $display("FAIL sb_addr: unexpected read at %h", mem_a);
         end else begin
            ea = exp_addr.pop_front();
            if (mem_a !== ea) begin
               errors++; $display("FAIL sb_addr: got %h expected %h", mem_a, ea);
            end
         end
      end
      if (resetq && pix_valid) begin
         checks++;
         if (exp_data.size() == 0) begin
            errors++; $display("FAIL sb_data: unexpected pixel %h", pix_data);
         end else begin
            ed = exp_data.pop_front();
            if (pix_data !== ed) begin
               errors++; $display("FAIL sb_data: got %h expected %h", pix_data, ed);
            end
         end
      end
   endtask

   task automatic check_drained(input string tag);
      checks++;
      if (exp_addr.size() != 0 || exp_data.size() != 0) begin
         errors++;
         $display("FAIL %s: leftover addr=%0d data=%0d expected 0 0", tag, exp_addr.size(), exp_data.size());
      end
      exp_addr.delete(); exp_data.delete();
   endtask

   // One full burst; optional simultaneous frame restart and re-edge at N+5
   task automatic do_burst(input bit with_int, input bit re_edge);
      if (with_int) model_restart();
      push_burst();
      seen_first = 1'b0;
      @(posedge clk); #1; dmao = 1'b1; int_in = with_int;
      @(negedge clk); tick_sb();
      for (int k = 1; k <= 18; k++) begin
         @(posedge clk); #1; dmao = (re_edge && k == 5); int_in = 1'b0;
         @(negedge clk); tick_sb();
      end
   endtask

   task automatic test_reset();
      resetq = 1'b0; dmao = 1'b0; int_in = 1'b0;
      model_restart();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (mem_rd !== 1'b0)     begin errors++; $display("FAIL rst_mem_rd: got %b expected 0", mem_rd); end
      checks++; if (mem_a !== 16'h0000)  begin errors++; $display("FAIL rst_mem_a: got %h expected 0000", mem_a); end
      checks++; if (pix_data !== 8'h00)  begin errors++; $display("FAIL rst_pix_data: got %h expected 00", pix_data); end
      checks++; if (pix_valid !== 1'b0)  begin errors++; $display("FAIL rst_pix_valid: got %b expected 0", pix_valid); end
      checks++; if (sc !== 2'b01)        begin errors++; $display("FAIL rst_sc: got %b expected 01", sc); end
      checks++; if (dma_busy !== 1'b0)   begin errors++; $display("FAIL rst_busy: got %b expected 0", dma_busy); end
      checks++; if (ovr !== 1'b0)        begin errors++; $display("FAIL rst_ovr: got %b expected 0", ovr); end
      @(posedge clk); #1; resetq = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   // First burst with cycle-exact strobe/state-code timing
   task automatic test_first_burst();
      logic exp_rd, exp_pv, exp_busy;
      logic [1:0] exp_sc;
      push_burst();
      seen_first = 1'b0;
      @(posedge clk); #1; dmao = 1'b1;
      for (int k = 0; k <= 18; k++) begin
         if (k > 0) begin @(posedge clk); #1; dmao = 1'b0; end
         @(negedge clk);
         tick_sb();
         exp_rd   = (k % 2 == 1) && (k <= 15);
         exp_pv   = (k % 2 == 1) && (k >= 3) && (k <= 17);
         exp_busy = (k >= 1) && (k <= 16);
         exp_sc   = exp_busy ? 2'b10 : 2'b01;
         checks++; if (mem_rd !== exp_rd)      begin errors++; $display("FAIL lat_mem_rd N+%0d: got %b expected %b", k, mem_rd, exp_rd); end
         checks++; if (pix_valid !== exp_pv)   begin errors++; $display("FAIL lat_pix_valid N+%0d: got %b expected %b", k, pix_valid, exp_pv); end
         checks++; if (sc !== exp_sc)          begin errors++; $display("FAIL lat_sc N+%0d: got %b expected %b", k, sc, exp_sc); end
         checks++; if (dma_busy !== exp_busy)  begin errors++; $display("FAIL lat_busy N+%0d: got %b expected %b", k, dma_busy, exp_busy); end
      end
      check_drained("first_burst_drain");
   endtask

   // Bursts 2..5: rows repeat four times, the fifth reads the next row
   task automatic test_row_repeat();
      for (int b = 2; b <= 5; b++) begin
         do_burst(1'b0, 1'b0);
         checks++;
         if (first_rd_addr !== ((b == 5) ? 16'h0908 : 16'h0900)) begin
            errors++; $display("FAIL row_repeat burst %0d: first addr %h expected %h", b, first_rd_addr, (b == 5) ? 16'h0908 : 16'h0900);
         end
      end
      check_drained("row_repeat_drain");
   endtask

   // 128 bursts cover the whole 256-byte page; the next one wraps to BASE
   task automatic test_wrap();
      for (int b = 6; b <= 128; b++) do_burst(1'b0, 1'b0);
      do_burst(1'b0, 1'b0);
      checks++;
      if (first_rd_addr !== 16'h0900) begin
         errors++; $display("FAIL wrap: first addr %h expected 0900", first_rd_addr);
      end
      check_drained("wrap_drain");
   endtask

   task automatic test_overrun();
      checks++;
      if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_pre: got %b expected 0", ovr); end
      do_burst(1'b0, 1'b1);
      check_drained("ovr_burst_drain");
      checks++;
      if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", ovr); end
      @(posedge clk); #1; int_in = 1'b1;
      @(posedge clk); #1; int_in = 1'b0;
      model_restart();
      @(negedge clk);
      checks++;
      if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", ovr); end
   endtask

   // Frame interrupt at N+6 kills the burst after two pixels
   task automatic test_abort();
      logic exp_pv;
      for (int i = 0; i < 3; i++) begin
         exp_addr.push_back(BASE + {8'h00, m_ptr + 8'(i)});
         if (i < 2) exp_data.push_back(ram_byte(BASE + {8'h00, m_ptr + 8'(i)}));
      end
      @(posedge clk); #1; dmao = 1'b1;
      @(negedge clk); tick_sb();
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1; dmao = 1'b0; int_in = (k == 6);
         @(negedge clk); tick_sb();
         exp_pv = (k == 3) || (k == 5);
         checks++;
         if (pix_valid !== exp_pv) begin errors++; $display("FAIL abort_pv N+%0d: got %b expected %b", k, pix_valid, exp_pv); end
      end
      checks++;
      if (dma_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", dma_busy); end
      check_drained("abort_drain");
      model_restart();
      do_burst(1'b0, 1'b0);
      checks++;
      if (first_rd_addr !== 16'h0900) begin errors++; $display("FAIL abort_next: first addr %h expected 0900", first_rd_addr); end
      check_drained("abort_next_drain");
   endtask

   // Simultaneous int_in and dmao edges: restart then burst from BASE
   task automatic test_simultaneous();
      for (int b = 0; b < 4; b++) do_burst(1'b0, 1'b0);
      do_burst(1'b1, 1'b0);
      checks++;
      if (first_rd_addr !== 16'h0900) begin errors++; $display("FAIL simul: first addr %h expected 0900", first_rd_addr); end
      check_drained("simul_drain");
   endtask

   // Reset asserted at N+4 clears outputs at once; next burst starts at BASE
   task automatic test_reset_mid();
      do_burst(1'b0, 1'b0);
      check_drained("pre_reset_drain");
      exp_addr.push_back(BASE + {8'h00, m_ptr});
      exp_addr.push_back(BASE + {8'h00, m_ptr + 8'h01});
      exp_data.push_back(ram_byte(BASE + {8'h00, m_ptr}));
      @(posedge clk); #1; dmao = 1'b1;
      @(negedge clk); tick_sb();
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1; dmao = 1'b0;
         @(negedge clk); tick_sb();
      end
      @(posedge clk); #1; resetq = 1'b0;
      #1;
      checks++;
      if (mem_rd !== 1'b0 || pix_valid !== 1'b0 || sc !== 2'b01 || dma_busy !== 1'b0 ||
          mem_a !== 16'h0000 || pix_data !== 8'h00 || ovr !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: rd=%b pv=%b sc=%b busy=%b a=%h d=%h ovr=%b expected 0 0 01 0 0000 00 0",
                  mem_rd, pix_valid, sc, dma_busy, mem_a, pix_data, ovr);
      end
      check_drained("reset_mid_drain");
      model_restart();
      repeat (2) @(posedge clk);
      #1; resetq = 1'b1;
      do_burst(1'b0, 1'b0);
      checks++;
      if (first_rd_addr !== 16'h0900) begin errors++; $display("FAIL reset_next: first addr %h expected 0900", first_rd_addr); end
      check_drained("reset_next_drain");
   endtask

   initial begin
      test_reset();
      test_first_burst();
      test_row_repeat();
      test_wrap();
      test_overrun();
      test_abort();
      test_simultaneous();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
